decoder_rr_arbiter: RTL and testbench



---
 rtl/decoder_rr_arbiter_if.sv | 22 ++
 rtl/decoder_rr_arbiter.sv | 105 ++++++++++
 tb/tb_decoder_rr_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bus between the requesters and the round-robin arbiter.
// The master side drives requests and release; the slave side is the arbiter.
interface decoder_rr_arbiter_if #(
  parameter int N = 3
);
  logic [(1<<N)-1:0] req;
  logic              done;
  logic [(1<<N)-1:0] grant;
  logic [N-1:0]      grant_idx;
  logic              grant_valid;
  logic              timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter over 2**N requesters; the registered winner index is
// decoded into a one-hot grant, with an optional hold-time limit per grant.
module decoder_rr_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  decoder_rr_arbiter_if.slave  bus
);

  localparam int W         = 1 << N;
  localparam int HW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [N-1:0]  ptr, ptr_n;
  logic [N-1:0]  grant_idx, grant_idx_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          timeout, timeout_n;

  logic [N-1:0]  winner;
  logic [N-1:0]  cand;
  logic          found;
  logic          release_req;
  logic          hold_expired;

  // Scan ptr, ptr+1, ... wrapping modulo 2**N; the N-bit add does the wrap.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int i = 0; i < W; i++) begin
      cand = ptr + N'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign release_req  = bus.done || !bus.req[grant_idx];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HW'(HOLD_LAST));

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    grant_idx_n = grant_idx;
    hold_cnt_n  = hold_cnt;
    timeout_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_idx_n = winner;
          hold_cnt_n  = '0;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        // Release wins over an expiring hold timer, so timeout stays low then.
        if (release_req || hold_expired) begin
          state_n   = IDLE;
          ptr_n     = grant_idx + N'(1);
          timeout_n = !release_req;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_idx <= grant_idx_n;
      hold_cnt  <= hold_cnt_n;
      timeout   <= timeout_n;
    end
  end

  // Grant is a pure decode of registered state: no req-to-grant comb path.
  always_comb begin
    bus.grant            = '0;
    bus.grant[grant_idx] = (state == BUSY);
  end

  assign bus.grant_idx   = grant_idx;
  assign bus.grant_valid = (state == BUSY);
  assign bus.timeout     = timeout;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter (N=3, MAX_HOLD=4): directed
// vector table, hand-written sequences, then random traffic against a model.
module tb_decoder_rr_arbiter;

  localparam int N        = 3;
  localparam int R        = 1 << N;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic reset;

  decoder_rr_arbiter_if #(.N(N)) bus ();

  decoder_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, for how many cycles it has held it,
  // and which requester has first claim on the next scan.
  bit m_owned;
  int m_owner;
  int m_age;
  int m_next;
  bit m_timeout;

  task automatic model_edge(input bit rst, input logic [R-1:0] rq, input bit dn);
    m_timeout = 0;
    if (rst) begin
      m_owned = 0; m_owner = 0; m_age = 0; m_next = 0;
    end else if (!m_owned) begin
      if (rq != 0) begin
        for (int k = 0; k < R; k++) begin
          if (rq[(m_next + k) % R]) begin
            m_owner = (m_next + k) % R;
            break;
          end
        end
        m_owned = 1;
        m_age   = 1;
      end
    end else if (dn || !rq[m_owner]) begin
      m_owned = 0;
      m_next  = (m_owner + 1) % R;
    end else if (MAX_HOLD != 0 && m_age >= MAX_HOLD) begin
      m_owned   = 0;
      m_next    = (m_owner + 1) % R;
      m_timeout = 1;
    end else begin
      m_age++;
    end
  endtask

  // Advance one edge with the currently driven inputs; sample 1ns later.
  task automatic tick();
    model_edge(reset, bus.req, bus.done);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".grant"},   32'(bus.grant),       m_owned ? 32'(1 << m_owner) : 32'd0);
    check({tag, ".valid"},   32'(bus.grant_valid), 32'(m_owned));
    check({tag, ".idx"},     32'(bus.grant_idx),   32'(m_owner));
    check({tag, ".timeout"}, 32'(bus.timeout),     32'(m_timeout));
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] req;
    bit         done;
    logic [7:0] grant;
    bit         valid;
    logic [2:0] idx;
    bit         tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit rst, logic [7:0] req, bit done,
                             logic [7:0] grant, bit valid, logic [2:0] idx, bit tmo);
    vec_t r;
    r.rst = rst; r.req = req; r.done = done;
    r.grant = grant; r.valid = valid; r.idx = idx; r.tmo = tmo;
    return r;
  endfunction

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;

    // Directed table: reset, pointer fairness, idle done, timeout,
    // done-at-limit, owner drop, reset mid-grant on idx 5.
    vecs.push_back(v(1, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 8'h01, 0, 8'h01, 1, 0, 0));
    vecs.push_back(v(0, 8'h01, 1, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 8'h81, 0, 8'h80, 1, 7, 0));
    vecs.push_back(v(0, 8'h81, 1, 8'h00, 0, 7, 0));
    vecs.push_back(v(0, 8'h81, 0, 8'h01, 1, 0, 0));
    vecs.push_back(v(0, 8'h81, 1, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 1, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h00, 0, 2, 1));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h04, 1, 8'h00, 0, 2, 0));
    vecs.push_back(v(0, 8'h04, 0, 8'h04, 1, 2, 0));
    vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 2, 0));
    vecs.push_back(v(0, 8'h20, 0, 8'h20, 1, 5, 0));
    vecs.push_back(v(0, 8'h20, 0, 8'h20, 1, 5, 0));
    vecs.push_back(v(1, 8'h20, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 8'h21, 0, 8'h01, 1, 0, 0));
    vecs.push_back(v(0, 8'h21, 1, 8'h00, 0, 0, 0));

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      bus.req  = vecs[i].req;
      bus.done = vecs[i].done;
      tick();
      check($sformatf("vec%0d.grant", i),   32'(bus.grant),       32'(vecs[i].grant));
      check($sformatf("vec%0d.valid", i),   32'(bus.grant_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d.idx", i),     32'(bus.grant_idx),   32'(vecs[i].idx));
      check($sformatf("vec%0d.timeout", i), 32'(bus.timeout),     32'(vecs[i].tmo));
    end

    // Round robin with wrap: all requesting, each owner releases after one cycle.
    reset = 1'b1; bus.req = '0; bus.done = 1'b0;
    tick();
    reset = 1'b0; bus.req = 8'hFF;
    for (int k = 0; k <= R; k++) begin
      bus.done = 1'b0;
      tick();
      check($sformatf("rr%0d.grant", k), 32'(bus.grant), 32'(1 << (k % R)));
      bus.done = 1'b1;
      tick();
      check($sformatf("rr%0d.gap", k), 32'(bus.grant), 32'd0);
    end

    // Quiet bus for ten cycles, then a done pulse in IDLE must not move ptr.
    bus.req = '0; bus.done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("idle%0d.grant", k), 32'(bus.grant), 32'd0);
    end
    bus.done = 1'b1;
    tick();
    check("idle_done.grant", 32'(bus.grant), 32'd0);
    bus.done = 1'b0; bus.req = 8'h03;
    tick();
    check("after_idle_done.grant", 32'(bus.grant), 32'h02);

    // Random traffic against the model.
    begin
      logic [R-1:0] rq;
      rq = '0;
      for (int c = 0; c < 1500; c++) begin
        reset = ($urandom_range(0, 99) == 0);
        case ($urandom_range(0, 5))
          0:       rq = R'($urandom);
          1:       rq = rq & R'($urandom);
          2:       rq = rq | R'(1 << $urandom_range(0, R - 1));
          default: ;
        endcase
        bus.req  = rq;
        bus.done = ($urandom_range(0, 4) == 0);
        tick();
        check_model($sformatf("rand%0d", c));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
